// File: rtl/sifh_hist_if.sv
// Sample stream and per-frame result bundle of the SiFH histogram engine.
// The source drives the master side, the engine sits on the slave side.
interface sifh_hist_if #(
    parameter int NP     = 12,
    parameter int PIXELS = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [NP-1:0]        in_data;
    logic [NP*PIXELS-1:0] result;
    logic [PIXELS-1:0]    no_hit;
    logic                 result_valid;
    logic                 pass_fine;

    modport master (
        output in_valid, in_data,
        input  in_ready, result, no_hit, result_valid, pass_fine
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, result, no_hit, result_valid, pass_fine
    );
endinterface

// File: rtl/sifh_hist_engine.sv
// Two-pass SiFH histogram engine: coarse histogram picks a window,
// fine histogram inside that window gives one peak per pixel per frame.
module sifh_hist_engine #(
    parameter int NP       = 12,
    parameter int NB       = 7,
    parameter int PIXELS   = 4,
    parameter int DATA_NUM = 2,
    parameter int ACQ_NUM  = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       res,
    sifh_hist_if.slave bus
);
    localparam int NBINS = 1 << NB;
    localparam int SH    = NP - NB;
    localparam int PW    = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int DW    = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam int AW    = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
    localparam int ENT   = PIXELS * NBINS;
    localparam logic [NP:0] HALF  = (NP+1)'(NBINS / 2);
    localparam logic [NP:0] TOP   = (NP+1)'((1 << NP) - 1);
    localparam logic [NP:0] LOMAX = (NP+1)'((1 << NP) - NBINS);
    localparam logic [NP:0] CMID  = (NP+1)'(1 << (SH - 1));

    typedef enum logic [2:0] {
        S_COARSE, S_DRAIN_C, S_WIN, S_FINE, S_DRAIN_F, S_OUT
    } state_e;

    state_e state_q, state_d;
    logic   drn_q, drn_d;
    logic   clr, win, out;
    logic   acc, last;

    logic [DW-1:0] dat_q;
    logic [PW-1:0] pix_q;
    logic [AW-1:0] acq_q;

    assign bus.in_ready  = (state_q == S_COARSE) || (state_q == S_FINE);
    assign bus.pass_fine = (state_q == S_FINE) || (state_q == S_DRAIN_F);
    assign acc  = bus.in_valid && bus.in_ready;
    assign last = acc && (dat_q == DW'(DATA_NUM - 1))
                      && (pix_q == PW'(PIXELS - 1))
                      && (acq_q == AW'(ACQ_NUM - 1));

    always_comb begin
        state_d = state_q;
        drn_d   = 1'b0;
        clr     = 1'b0;
        win     = 1'b0;
        out     = 1'b0;
        unique case (state_q)
            S_COARSE:  if (last) state_d = S_DRAIN_C;
            S_DRAIN_C: begin
                drn_d = !drn_q;
                if (drn_q) state_d = S_WIN;
            end
            S_WIN: begin
                win     = 1'b1;
                clr     = 1'b1;
                state_d = S_FINE;
            end
            S_FINE:    if (last) state_d = S_DRAIN_F;
            S_DRAIN_F: begin
                drn_d = !drn_q;
                if (drn_q) begin
                    state_d = S_OUT;
                    out     = 1'b1;
                end
            end
            S_OUT: begin
                clr     = 1'b1;
                state_d = S_COARSE;
            end
            default: state_d = S_COARSE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_COARSE;
            drn_q   <= 1'b0;
            dat_q   <= '0;
            pix_q   <= '0;
            acq_q   <= '0;
        end else begin
            state_q <= state_d;
            drn_q   <= drn_d;
            if (acc) begin
                if (dat_q == DW'(DATA_NUM - 1)) begin
                    dat_q <= '0;
                    if (pix_q == PW'(PIXELS - 1)) begin
                        pix_q <= '0;
                        acq_q <= (acq_q == AW'(ACQ_NUM - 1)) ? '0 : acq_q + 1'b1;
                    end else begin
                        pix_q <= pix_q + 1'b1;
                    end
                end else begin
                    dat_q <= dat_q + 1'b1;
                end
            end
        end
    end

    logic [NP-1:0] lo_q [PIXELS];
    logic [NP-1:0] c_q  [PIXELS];
    logic [NP:0]   dx;
    logic          s1_hit;
    logic [NB-1:0] s1_bin;

    always_comb begin
        dx     = {1'b0, bus.in_data} - {1'b0, lo_q[pix_q]};
        s1_hit = acc;
        s1_bin = bus.in_data[NP-1 -: NB];
        if (state_q == S_FINE) begin
            s1_hit = acc && !dx[NP] && (dx < (NP+1)'(NBINS));
            s1_bin = dx[NB-1:0];
        end
    end

    logic             s1_v_q;
    logic [PW-1:0]    s1_pix_q;
    logic [NB-1:0]    s1_bin_q;
    logic [CNT_W-1:0] cnt_q [ENT];
    logic [ENT-1:0]   vld_q;
    logic [PW+NB-1:0] addr;
    logic [CNT_W-1:0] cnt_new;

    // The bin write lands before the next read, so same-bin hits chain.
    assign addr = {s1_pix_q, s1_bin_q};

    always_comb begin
        if (!vld_q[addr])      cnt_new = CNT_W'(1);
        else if (&cnt_q[addr]) cnt_new = cnt_q[addr];
        else                   cnt_new = cnt_q[addr] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (s1_v_q) cnt_q[addr] <= cnt_new;
    end

    logic             s2_v_q;
    logic [PW-1:0]    s2_pix_q;
    logic [NB-1:0]    s2_bin_q;
    logic [CNT_W-1:0] s2_cnt_q;
    logic [CNT_W-1:0] max_q  [PIXELS];
    logic [CNT_W-1:0] max_d  [PIXELS];
    logic [NB-1:0]    peak_q [PIXELS];
    logic [NB-1:0]    peak_d [PIXELS];

    always_comb begin
        max_d  = max_q;
        peak_d = peak_q;
        if (clr) begin
            for (int p = 0; p < PIXELS; p++) begin
                max_d[p]  = '0;
                peak_d[p] = '0;
            end
        end else if (s2_v_q && (s2_cnt_q > max_q[s2_pix_q])) begin
            max_d[s2_pix_q]  = s2_cnt_q;
            peak_d[s2_pix_q] = s2_bin_q;
        end
    end

    logic [NP:0] cw [PIXELS];
    logic [NP:0] lw [PIXELS];

    // Window is centred on the coarse peak but never leaves the code range.
    always_comb begin
        for (int p = 0; p < PIXELS; p++) begin
            cw[p] = ((NP+1)'(peak_q[p]) << SH) + CMID;
            if (cw[p] < HALF)             lw[p] = '0;
            else if (cw[p] + HALF > TOP)  lw[p] = LOMAX;
            else                          lw[p] = cw[p] - HALF;
        end
    end

    logic [NP*PIXELS-1:0] result_q;
    logic [PIXELS-1:0]    no_hit_q;
    logic                 rv_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            s1_v_q   <= 1'b0;
            s1_pix_q <= '0;
            s1_bin_q <= '0;
            s2_v_q   <= 1'b0;
            s2_pix_q <= '0;
            s2_bin_q <= '0;
            s2_cnt_q <= '0;
            vld_q    <= '0;
            result_q <= '0;
            no_hit_q <= '0;
            rv_q     <= 1'b0;
            for (int p = 0; p < PIXELS; p++) begin
                max_q[p]  <= '0;
                peak_q[p] <= '0;
                lo_q[p]   <= '0;
                c_q[p]    <= '0;
            end
        end else begin
            s1_v_q   <= s1_hit;
            s1_pix_q <= pix_q;
            s1_bin_q <= s1_bin;
            s2_v_q   <= s1_v_q;
            s2_pix_q <= s1_pix_q;
            s2_bin_q <= s1_bin_q;
            s2_cnt_q <= cnt_new;
            rv_q     <= out;
            if (clr)         vld_q       <= '0;
            else if (s1_v_q) vld_q[addr] <= 1'b1;
            for (int p = 0; p < PIXELS; p++) begin
                max_q[p]  <= max_d[p];
                peak_q[p] <= peak_d[p];
                if (win) begin
                    lo_q[p] <= NP'(lw[p]);
                    c_q[p]  <= NP'(cw[p]);
                end
                if (out) begin
                    no_hit_q[p] <= (max_d[p] == '0);
                    result_q[p*NP +: NP] <= (max_d[p] == '0) ? c_q[p]
                                          : lo_q[p] + NP'(peak_d[p]);
                end
            end
        end
    end

    assign bus.result       = result_q;
    assign bus.no_hit       = no_hit_q;
    assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_sifh_hist_engine.sv
// Bench for sifh_hist_engine: directed frames plus randomized frames
// checked against a per-sample histogram reference model.
module tb_sifh_hist_engine;
    logic clk = 1'b0;
    logic res;
    int   checks = 0;
    int   errors = 0;
    int   rva = 0;
    int   rvb = 0;
    logic [47:0] ra = '0;
    logic [47:0] rb = '0;
    logic [3:0]  na = '0;
    logic [3:0]  nb = '0;

    always #5 clk = ~clk;

    sifh_hist_if #(.NP(12), .PIXELS(4)) ifa ();
    sifh_hist_if #(.NP(12), .PIXELS(4)) ifb ();

    sifh_hist_engine #(
        .NP(12), .NB(7), .PIXELS(4), .DATA_NUM(2), .ACQ_NUM(4), .CNT_W(8)
    ) ua (.clk(clk), .res(res), .bus(ifa));

    sifh_hist_engine #(
        .NP(12), .NB(7), .PIXELS(4), .DATA_NUM(1), .ACQ_NUM(8), .CNT_W(2)
    ) ub (.clk(clk), .res(res), .bus(ifb));

    always @(negedge clk) begin
        if (ifa.result_valid) begin
            rva <= rva + 1;
            ra  <= ifa.result;
            na  <= ifa.no_hit;
        end
        if (ifb.result_valid) begin
            rvb <= rvb + 1;
            rb  <= ifb.result;
            nb  <= ifb.no_hit;
        end
    end

    task automatic chk(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setv(input int w, input logic v, input logic [11:0] d);
        if (w == 0) begin
            ifa.in_valid = v;
            ifa.in_data  = d;
        end else begin
            ifb.in_valid = v;
            ifb.in_data  = d;
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 0) ? ifa.in_ready : ifb.in_ready;
    endfunction

    function automatic logic pf(input int w);
        return (w == 0) ? ifa.pass_fine : ifb.pass_fine;
    endfunction

    // Present one sample; it is taken on the posedge after this returns.
    task automatic send(input int w, input logic [11:0] d, output int st);
        st = 0;
        @(negedge clk);
        setv(w, 1'b1, d);
        while (!rdy(w) && st < 20) begin
            @(negedge clk);
            st++;
        end
        if (st >= 20) chk("ready_timeout", rdy(w), 1);
    endtask

    function automatic void model(input logic [11:0] co[$],
                                  input logic [11:0] fi[$],
                                  input int dn, input int cmax,
                                  output logic [47:0] r,
                                  output logic [3:0] nh);
        int cnt [4][128];
        int mx [4];
        int pk [4];
        int lo [4];
        int c [4];
        int p, b, v;
        for (int q = 0; q < 4; q++) begin
            mx[q] = 0;
            pk[q] = 0;
            for (int k = 0; k < 128; k++) cnt[q][k] = 0;
        end
        foreach (co[i]) begin
            p = (i / dn) % 4;
            b = int'(co[i]) >> 5;
            if (cnt[p][b] < cmax) cnt[p][b]++;
            if (cnt[p][b] > mx[p]) begin
                mx[p] = cnt[p][b];
                pk[p] = b;
            end
        end
        for (int q = 0; q < 4; q++) begin
            c[q] = pk[q] * 32 + 16;
            if (c[q] < 64)              lo[q] = 0;
            else if (c[q] + 64 > 4095)  lo[q] = 4096 - 128;
            else                        lo[q] = c[q] - 64;
            mx[q] = 0;
            pk[q] = 0;
            for (int k = 0; k < 128; k++) cnt[q][k] = 0;
        end
        foreach (fi[i]) begin
            p = (i / dn) % 4;
            v = int'(fi[i]);
            if (v >= lo[p] && v < lo[p] + 128) begin
                b = v - lo[p];
                if (cnt[p][b] < cmax) cnt[p][b]++;
                if (cnt[p][b] > mx[p]) begin
                    mx[p] = cnt[p][b];
                    pk[p] = b;
                end
            end
        end
        for (int q = 0; q < 4; q++) begin
            r[q*12 +: 12] = (mx[q] > 0) ? 12'(lo[q] + pk[q]) : 12'(c[q]);
            nh[q] = (mx[q] == 0);
        end
    endfunction

    function automatic logic [11:0] jit(input int base, input int span);
        int v;
        v = base + int'($urandom_range(0, 2 * span)) - span;
        if (v < 0) v = 0;
        if (v > 4095) v = 4095;
        return 12'(v);
    endfunction

    task automatic gen(input int dn, input int acq,
                       output logic [11:0] co[$], output logic [11:0] fi[$]);
        int base [4];
        co = {};
        fi = {};
        for (int q = 0; q < 4; q++) begin
            base[q] = int'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) == 0)
                base[q] = ($urandom_range(0, 1) == 1) ? 10 : 4085;
        end
        for (int i = 0; i < dn * 4 * acq; i++) begin
            int p;
            p = (i / dn) % 4;
            co.push_back(jit(base[p], 40));
            if ($urandom_range(0, 7) == 0)
                fi.push_back(12'($urandom_range(0, 4095)));
            else
                fi.push_back(jit(base[p], 40));
        end
    endtask

    task automatic frame(input int w, input logic [11:0] co[$],
                         input logic [11:0] fi[$], input int abort_at);
        int st, extra, rv0;
        logic [47:0] er;
        logic [3:0]  en;
        rv0   = (w == 0) ? rva : rvb;
        extra = 0;
        foreach (co[i]) begin
            send(w, co[i], st);
            if (i == 0) chk("pf_coarse", pf(w), 0);
            else extra += st;
        end
        foreach (fi[i]) begin
            send(w, fi[i], st);
            if (i == 0) begin
                chk("stall_c2f", st, 3);
                chk("pf_fine", pf(w), 1);
            end else begin
                extra += st;
            end
            if (i == abort_at) begin
                @(negedge clk);
                res = 1'b1;
                #1;
                chk("abort_result", ifa.result, 0);
                chk("abort_no_hit", ifa.no_hit, 0);
                chk("abort_rv", ifa.result_valid, 0);
                chk("abort_pf", ifa.pass_fine, 0);
                @(negedge clk);
                res = 1'b0;
                setv(w, 1'b0, 12'h0);
                return;
            end
        end
        chk("stall_in_pass", extra, 0);
        st = 0;
        @(negedge clk);
        while (!rdy(w) && st < 20) begin
            st++;
            @(negedge clk);
        end
        setv(w, 1'b0, 12'h0);
        chk("stall_f2c", st, 3);
        model(co, fi, (w == 0) ? 2 : 1, (w == 0) ? 255 : 3, er, en);
        chk("rv_pulses", ((w == 0) ? rva : rvb) - rv0, 1);
        chk("result", (w == 0) ? ra : rb, er);
        chk("no_hit", (w == 0) ? na : nb, en);
    endtask

    initial begin
        logic [11:0] co[$];
        logic [11:0] fi[$];
        logic [11:0] tbl [4];
        tbl[0] = 12'h5A3;
        tbl[1] = 12'h005;
        tbl[2] = 12'hFFE;
        tbl[3] = 12'h400;
        res = 1'b1;
        setv(0, 1'b0, 12'h0);
        setv(1, 1'b0, 12'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_result", ifa.result, 0);
        chk("rst_no_hit", ifa.no_hit, 0);
        chk("rst_rv", ifa.result_valid, 0);
        chk("rst_pf", ifa.pass_fine, 0);
        res = 1'b0;
        @(negedge clk);
        chk("rst_ready_a", ifa.in_ready, 1);
        chk("rst_ready_b", ifb.in_ready, 1);

        co = {};
        fi = {};
        for (int i = 0; i < 32; i++) begin
            co.push_back(tbl[(i / 2) % 4]);
            fi.push_back(tbl[(i / 2) % 4]);
        end
        frame(0, co, fi, -1);
        chk("a1_result", ra, 48'h400_FFE_005_5A3);
        chk("a1_no_hit", na, 4'b0000);

        fi = {};
        for (int i = 0; i < 32; i++)
            fi.push_back(((i / 2) % 4 == 0) ? 12'h100 : tbl[(i / 2) % 4]);
        frame(0, co, fi, -1);
        chk("a2_result", ra, 48'h400_FFE_005_5B0);
        chk("a2_no_hit", na, 4'b0001);

        gen(2, 4, co, fi);
        frame(0, co, fi, 10);
        for (int k = 0; k < 4; k++) begin
            gen(2, 4, co, fi);
            frame(0, co, fi, -1);
        end

        co = {};
        fi = {};
        for (int i = 0; i < 32; i++) begin
            if (i % 4 == 0) begin
                co.push_back((i / 4 < 3) ? 12'h100 : 12'h200);
                fi.push_back(12'h100);
            end else begin
                co.push_back(tbl[i % 4]);
                fi.push_back(tbl[i % 4]);
            end
        end
        frame(1, co, fi, -1);
        chk("b1_result0", rb[11:0], 12'h100);
        chk("b1_no_hit0", nb[0], 1'b0);

        for (int k = 0; k < 2; k++) begin
            gen(1, 8, co, fi);
            frame(1, co, fi, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
